uart_tx: RTL

UART serial transmitter and companion to the UART receiver on the same baud-tick domain. Accepts bytes over a valid/ready handshake into a one-entry holding register and serialises them LSB-first onto `tx` as start bit, data bits, optional parity and stop bit(s). Every bit period is paced by the shared `enable_clk` baud tick. The holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_holdreg.sv | 57 +++++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e    - frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   UART_IDLE_LEVEL - level of the serial line between frames
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_holdreg.sv
// uart_tx_holdreg: one-entry holding register in front of the UART shifter.
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   tx_valid, tx_data - byte offered by the producer
//   load_i            - the shifter takes the held byte on this edge
//   tx_ready          - register empty, a byte can be accepted
//   full_o            - register holds a byte waiting for the shifter
//   data_o            - the held byte
module uart_tx_holdreg #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 load_i,
  output logic                 tx_ready,
  output logic                 full_o,
  output logic [DATA_BITS-1:0] data_o
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 accept;

  // Accept and load never coincide: load needs a full register, accept an empty one.
  assign accept = tx_valid && !full_q;

  always_comb begin
    full_d = full_q;
    if (load_i) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Payload needs no reset: it is only consumed while full_q is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= tx_data;
    end
  end

  assign tx_ready = !full_q;
  assign full_o   = full_q;
  assign data_o   = data_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter paced by a shared baud tick.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Build option: define UART_TX_PARITY_EN to add the parity bit (PARITY_ODD picks the sense).
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   enable_clk        - one-cycle baud tick, one per bit period
//   tx_valid, tx_data - byte handshake into the holding register
//   tx_ready          - holding register empty
//   tx                - serial line, idle high, registered
//   busy              - a frame is on the line
//   tx_done           - one-cycle pulse when the last stop bit ends
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_clk,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int                CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_tx: unsupported DATA_BITS/STOP_BITS/PARITY_ODD");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  uart_tx_holdreg #(
    .DATA_BITS(DATA_BITS)
  ) u_holdreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .load_i   (load),
    .tx_ready (tx_ready),
    .full_o   (hold_full),
    .data_o   (hold_data)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    if (enable_clk) begin
      case (state_q)
        IDLE: begin
          if (hold_full) begin
            load    = 1'b1;
            shift_d = hold_data;
            tx_d    = ~UART_IDLE_LEVEL;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = parity_bit(hold_data);
`endif
          end
        end
        START: begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            tx_d       = par_q;
            state_d    = PARITY;
`else
            tx_d       = UART_IDLE_LEVEL;
            state_d    = STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          tx_d       = UART_IDLE_LEVEL;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (STOP_BITS == 2 && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // A waiting byte starts on the same tick: no idle bit between frames.
            if (hold_full) begin
              load    = 1'b1;
              shift_d = hold_data;
              tx_d    = ~UART_IDLE_LEVEL;
              state_d = START;
`ifdef UART_TX_PARITY_EN
              par_d   = parity_bit(hold_data);
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = done_q;

endmodule
